// File: rtl/alu_mdu.sv
// alu_mdu: registered RV32I ALU plus RV32M multiply/divide unit.
//
// Base ops (ADD..SRA) and illegal opcodes finish in one cycle. MUL and DIV
// families share one radix-2 iterative datapath that takes WIDTH iterations,
// and o_ready is held low while such an op is in flight.
//
// Ports:
//   i_clk       clock, rising edge
//   i_rst       synchronous active-high reset
//   i_valid     request valid, taken when o_ready=1
//   o_ready     block idle, can accept a request
//   i_alu_op    5-bit opcode (0..17 legal, 18..31 give result 0)
//   i_op_a      operand A (rs1)
//   i_op_b      operand B (rs2 or immediate)
//   o_valid     one-cycle pulse marking o_alu_data valid
//   o_alu_data  result, held until the next o_valid
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for a request; base ops complete here in one cycle
// MUL   | shift-add, one multiplier bit per cycle
// DIV   | restoring shift-subtract, one quotient bit per cycle
// DONE  | sign correction, result select, o_valid pulse on the next cycle
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [4:0]       i_alu_op,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_alu_data
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLT    = 5'd2;
  localparam logic [4:0] OP_SLTU   = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_OR     = 5'd5;
  localparam logic [4:0] OP_AND    = 5'd6;
  localparam logic [4:0] OP_SLL    = 5'd7;
  localparam logic [4:0] OP_SRL    = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;
  localparam logic [4:0] OP_MUL    = 5'd10;
  localparam logic [4:0] OP_MULH   = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12;
  localparam logic [4:0] OP_MULHU  = 5'd13;
  localparam logic [4:0] OP_DIV    = 5'd14;
  localparam logic [4:0] OP_DIVU   = 5'd15;
  localparam logic [4:0] OP_REM    = 5'd16;
  localparam logic [4:0] OP_REMU   = 5'd17;

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             r_state, w_next;
  logic [4:0]         r_op;
  logic [WIDTH-1:0]   r_hi;      // MUL: accumulator high half; DIV: partial remainder
  logic [WIDTH-1:0]   r_lo;      // MUL: multiplier/product low half; DIV: dividend/quotient
  logic [WIDTH-1:0]   r_mag;     // MUL: multiplicand magnitude; DIV: divisor magnitude
  logic [SHW-1:0]     r_cnt;
  logic               r_neg_res; // product or quotient is negative
  logic               r_neg_rem; // remainder takes the sign of A
  logic               r_valid;
  logic [WIDTH-1:0]   r_data;

  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_base;
  logic               w_is_mul, w_is_div;
  logic               w_a_signed, w_b_signed;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic               w_div_zero, w_div_ovf;
  logic               w_accept;
  logic               w_last;

  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_diff;
  logic               w_div_ge;
  logic [WIDTH-1:0]   w_div_rem;
  logic [WIDTH-1:0]   w_div_q;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo, w_rem;
  logic [WIDTH-1:0]   w_final;

  assign o_ready    = (r_state == IDLE);
  assign o_valid    = r_valid;
  assign o_alu_data = r_data;

  assign w_accept = i_valid && (r_state == IDLE);
  assign w_last   = (r_cnt == SHW'(WIDTH-1));
  assign w_shamt  = i_op_b[SHW-1:0];

  assign w_is_mul = (i_alu_op >= OP_MUL) && (i_alu_op <= OP_MULHU);
  assign w_is_div = (i_alu_op >= OP_DIV) && (i_alu_op <= OP_REMU);

  assign w_a_signed = (i_alu_op == OP_MUL) || (i_alu_op == OP_MULH) ||
                      (i_alu_op == OP_MULHSU) || (i_alu_op == OP_DIV) ||
                      (i_alu_op == OP_REM);
  assign w_b_signed = (i_alu_op == OP_MUL) || (i_alu_op == OP_MULH) ||
                      (i_alu_op == OP_DIV) || (i_alu_op == OP_REM);

  assign w_a_neg = w_a_signed && i_op_a[WIDTH-1];
  assign w_b_neg = w_b_signed && i_op_b[WIDTH-1];
  // MIN negates to itself, which is still the correct unsigned magnitude.
  assign w_a_mag = w_a_neg ? (~i_op_a + 1'b1) : i_op_a;
  assign w_b_mag = w_b_neg ? (~i_op_b + 1'b1) : i_op_b;

  assign w_div_zero = (i_op_b == '0);
  assign w_div_ovf  = ((i_alu_op == OP_DIV) || (i_alu_op == OP_REM)) &&
                      (i_op_a == MIN_VAL) && (i_op_b == '1);

  always_comb begin
    w_base = '0;
    case (i_alu_op)
      OP_ADD:  w_base = i_op_a + i_op_b;
      OP_SUB:  w_base = i_op_a - i_op_b;
      OP_SLT:  w_base = {{(WIDTH-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      OP_SLTU: w_base = {{(WIDTH-1){1'b0}}, (i_op_a < i_op_b)};
      OP_XOR:  w_base = i_op_a ^ i_op_b;
      OP_OR:   w_base = i_op_a | i_op_b;
      OP_AND:  w_base = i_op_a & i_op_b;
      OP_SLL:  w_base = i_op_a << w_shamt;
      OP_SRL:  w_base = i_op_a >> w_shamt;
      OP_SRA:  w_base = $signed(i_op_a) >>> w_shamt;
      default: w_base = '0;
    endcase
  end

  // Shift-add step: conditionally add the multiplicand into the high half,
  // then shift the whole product right, consuming one multiplier bit.
  assign w_mul_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mag} : '0);
  assign w_mul_next = {w_mul_sum, r_lo[WIDTH-1:1]};

  // Restoring step: the partial remainder stays below the divisor, so the
  // shifted value fits in WIDTH+1 bits and the borrow bit decides the quotient.
  assign w_div_sh   = {r_hi, r_lo[WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, r_mag};
  assign w_div_ge   = ~w_div_diff[WIDTH];
  assign w_div_rem  = w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0];
  assign w_div_q    = {r_lo[WIDTH-2:0], w_div_ge};

  assign w_prod = r_neg_res ? (~{r_hi, r_lo} + 1'b1) : {r_hi, r_lo};
  assign w_quo  = r_neg_res ? (~r_lo + 1'b1) : r_lo;
  assign w_rem  = r_neg_rem ? (~r_hi + 1'b1) : r_hi;

  always_comb begin
    w_final = '0;
    case (r_op)
      OP_MUL:                        w_final = w_prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  w_final = w_prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               w_final = w_quo;
      OP_REM, OP_REMU:               w_final = w_rem;
      default:                       w_final = '0;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_valid) begin
          if (w_is_mul)      w_next = MUL;
          else if (w_is_div) w_next = (w_div_zero || w_div_ovf) ? DONE : DIV;
        end
      end
      MUL:     if (w_last) w_next = DONE;
      DIV:     if (w_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op      <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_mag     <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_valid   <= 1'b0;
      r_data    <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op  <= i_alu_op;
            r_cnt <= '0;
            if (w_is_mul) begin
              r_hi      <= '0;
              r_lo      <= w_b_mag;
              r_mag     <= w_a_mag;
              r_neg_res <= w_a_neg ^ w_b_neg;
              r_neg_rem <= 1'b0;
            end else if (w_is_div) begin
              r_neg_res <= 1'b0;
              r_neg_rem <= 1'b0;
              if (w_div_zero) begin
                r_lo <= '1;
                r_hi <= i_op_a;
              end else if (w_div_ovf) begin
                r_lo <= MIN_VAL;
                r_hi <= '0;
              end else begin
                r_hi      <= '0;
                r_lo      <= w_a_mag;
                r_mag     <= w_b_mag;
                r_neg_res <= w_a_neg ^ w_b_neg;
                r_neg_rem <= w_a_neg;
              end
            end else begin
              r_data  <= w_base;
              r_valid <= 1'b1;
            end
          end
        end
        MUL: begin
          {r_hi, r_lo} <= w_mul_next;
          r_cnt        <= r_cnt + 1'b1;
        end
        DIV: begin
          r_hi  <= w_div_rem;
          r_lo  <= w_div_q;
          r_cnt <= r_cnt + 1'b1;
        end
        DONE: begin
          r_data  <= w_final;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;

  typedef struct {
    logic [31:0] data;
    int          exp_cyc;
  } sb_t;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // 32-bit instance
  logic        i_valid;
  logic [4:0]  i_op;
  logic [31:0] i_a, i_b;
  logic        o_ready, o_valid;
  logic [31:0] o_data;
  sb_t         q[$];
  int          vcount = 0;

  // 8-bit instance
  logic        i8_valid;
  logic [4:0]  i8_op;
  logic [7:0]  i8_a, i8_b;
  logic        o8_ready, o8_valid;
  logic [7:0]  o8_data;
  sb_t         q8[$];

  vec_t        vec[24];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mdu #(.WIDTH(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_alu_op(i_op), .i_op_a(i_a), .i_op_b(i_b),
    .o_valid(o_valid), .o_alu_data(o_data)
  );

  alu_mdu #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(i8_valid), .o_ready(o8_ready),
    .i_alu_op(i8_op), .i_op_a(i8_a), .i_op_b(i8_b),
    .o_valid(o8_valid), .o_alu_data(o8_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && o_valid) begin
      sb_t e;
      vcount++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid32: got data %h at cycle %0d expected no o_valid", o_data, cyc);
      end else begin
        e = q.pop_front();
        chk("data32", o_data, e.data);
        chk("latency32", cyc, e.exp_cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && o8_valid) begin
      sb_t e;
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid8: got data %h at cycle %0d expected no o_valid", o8_data, cyc);
      end else begin
        e = q8.pop_front();
        chk("data8", {24'h0, o8_data}, e.data);
        chk("latency8", cyc, e.exp_cyc);
      end
    end
  end

  task automatic drive32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input bit push);
    i_valid = 1'b1;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    if (push) q.push_back('{data: exp, exp_cyc: cyc + lat});
  endtask

  task automatic drive8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp, input int lat);
    i8_valid = 1'b1;
    i8_op    = op;
    i8_a     = a;
    i8_b     = b;
    q8.push_back('{data: {24'h0, exp}, exp_cyc: cyc + lat});
  endtask

  task automatic drain32(output bit busy_bad);
    busy_bad = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0) return;
      if (o_ready) busy_bad = 1'b1;
    end
    checks++;
    errors++;
    $display("FAIL timeout32: got %0d pending results expected 0", q.size());
    q.delete();
  endtask

  task automatic drain8();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (q8.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL timeout8: got %0d pending results expected 0", q8.size());
    q8.delete();
  endtask

  initial begin
    bit busy_bad;
    int v0;

    vec[0]  = '{5'd0,  32'd7,        32'd5,        32'd12,       1};
    vec[1]  = '{5'd1,  32'd3,        32'd5,        32'hFFFFFFFE, 1};
    vec[2]  = '{5'd2,  32'hFFFFFFFF, 32'd1,        32'd1,        1};
    vec[3]  = '{5'd3,  32'hFFFFFFFF, 32'd1,        32'd0,        1};
    vec[4]  = '{5'd9,  32'h80000000, 32'd36,       32'hF8000000, 1};
    vec[5]  = '{5'd4,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1};
    vec[6]  = '{5'd5,  32'h12340000, 32'h00005678, 32'h12345678, 1};
    vec[7]  = '{5'd6,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1};
    vec[8]  = '{5'd7,  32'h00000001, 32'd33,       32'h00000002, 1};
    vec[9]  = '{5'd8,  32'h80000000, 32'd4,        32'h08000000, 1};
    vec[10] = '{5'd25, 32'd7,        32'd5,        32'd0,        1};
    vec[11] = '{5'd10, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 34};
    vec[12] = '{5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        34};
    vec[13] = '{5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34};
    vec[14] = '{5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34};
    vec[15] = '{5'd10, 32'd1000,     32'd1000,     32'h000F4240, 34};
    vec[16] = '{5'd14, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
    vec[17] = '{5'd16, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
    vec[18] = '{5'd15, 32'd100,      32'd7,        32'd14,       34};
    vec[19] = '{5'd17, 32'd100,      32'd7,        32'd2,        34};
    vec[20] = '{5'd14, 32'd5,        32'd0,        32'hFFFFFFFF, 2};
    vec[21] = '{5'd17, 32'd5,        32'd0,        32'd5,        2};
    vec[22] = '{5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2};
    vec[23] = '{5'd16, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2};

    rst = 1'b1;
    i_valid = 1'b0; i_op = '0; i_a = '0; i_b = '0;
    i8_valid = 1'b0; i8_op = '0; i8_a = '0; i8_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'h0, o_ready}, 32'd1);
    chk("reset_valid", {31'h0, o_valid}, 32'd0);
    chk("reset_data", o_data, 32'd0);

    // Table-driven single requests
    foreach (vec[i]) begin
      chk($sformatf("vec%0d_ready_in", i), {31'h0, o_ready}, 32'd1);
      drive32(vec[i].op, vec[i].a, vec[i].b, vec[i].exp, vec[i].lat, 1'b1);
      @(posedge clk);
      #1 i_valid = 1'b0;
      i_a = $urandom;
      i_b = $urandom;
      drain32(busy_bad);
      if (vec[i].lat > 1) chk($sformatf("vec%0d_busy_ready", i), {31'h0, busy_bad}, 32'd0);
    end

    // Back-to-back base ops: one result per cycle
    v0 = vcount;
    for (int i = 0; i < 5; i++) begin
      drive32(5'd0, i, 32'd100, 32'd100 + i, 1, 1'b1);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    drain32(busy_bad);
    chk("b2b_count", vcount - v0, 32'd5);

    // i_valid held while MUL is busy: extra request must be ignored
    v0 = vcount;
    drive32(5'd10, 32'd6, 32'd7, 32'd42, 34, 1'b1);
    @(posedge clk);
    #1 i_op = 5'd0; i_a = 32'd1; i_b = 32'd1;
    repeat (5) @(posedge clk);
    #1 i_valid = 1'b0;
    drain32(busy_bad);
    repeat (5) @(negedge clk);
    chk("held_valid_count", vcount - v0, 32'd1);
    chk("held_busy_ready", {31'h0, busy_bad}, 32'd0);

    // Reset mid-MUL, with a competing request in the reset cycle
    v0 = vcount;
    drive32(5'd10, 32'd3, 32'd3, 32'd9, 34, 1'b0);
    @(posedge clk);
    #1 i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    drive32(5'd0, 32'd8, 32'd8, 32'd16, 1, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    i_valid = 1'b0;
    chk("abort_ready", {31'h0, o_ready}, 32'd1);
    chk("abort_valid", {31'h0, o_valid}, 32'd0);
    chk("abort_data", o_data, 32'd0);
    repeat (40) @(negedge clk);
    chk("abort_no_valid", vcount - v0, 32'd0);
    #1;
    drive32(5'd0, 32'd1, 32'd2, 32'd3, 1, 1'b1);
    @(posedge clk);
    #1 i_valid = 1'b0;
    drain32(busy_bad);

    // WIDTH=8 instance
    chk("w8_ready", {31'h0, o8_ready}, 32'd1);
    drive8(5'd13, 8'hFF, 8'hFF, 8'hFE, 10);
    @(posedge clk);
    #1 i8_valid = 1'b0;
    drain8();
    drive8(5'd7, 8'h01, 8'd9, 8'h02, 1);
    @(posedge clk);
    #1 i8_valid = 1'b0;
    drain8();
    drive8(5'd20, 8'h55, 8'h22, 8'h00, 1);
    @(posedge clk);
    #1 i8_valid = 1'b0;
    drain8();
    drive8(5'd14, 8'hF9, 8'h02, 8'hFD, 10);
    @(posedge clk);
    #1 i8_valid = 1'b0;
    drain8();
    drive8(5'd16, 8'h80, 8'hFF, 8'h00, 2);
    @(posedge clk);
    #1 i8_valid = 1'b0;
    drain8();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
